// File: rtl/oled_spi_tx.sv
// Buffered SPI byte transmitter for the SSD1306 PmodOLED link: FWFT FIFO of {dc,byte} feeding an MSB-first shifter.
// Optional byte counter port TX_CNT is built when OLED_SPI_TXCNT_EN is defined.
module oled_spi_tx #(
  parameter int CLK_DIV = 2,
  parameter int DEPTH   = 4,
  parameter int CS_GAP  = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WR_EN,
  input  logic [7:0] WR_DATA,
  input  logic       WR_DC,
  output logic       FULL,
  output logic       BUSY,
  output logic       CS,
  output logic       SDO,
  output logic       SCLK,
  output logic       DC
`ifdef OLED_SPI_TXCNT_EN
  , output logic [15:0] TX_CNT
`endif
);

  localparam int AW      = $clog2(DEPTH);
  localparam int HW      = $clog2(CLK_DIV + 1);
  localparam int GAP_CYC = CS_GAP * CLK_DIV;
  localparam int GW      = $clog2(GAP_CYC + 1);
  localparam logic [HW-1:0] H_LAST   = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] G_LAST   = GW'(GAP_CYC - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t        state, state_n;
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_n;
  logic [8:0]    head;
  logic          push, pop, empty;
  logic [HW-1:0] hcnt;
  logic          ph;
  logic [2:0]    bcnt;
  logic [GW-1:0] gcnt;
  logic [7:0]    sr;
  logic          half_end, byte_end;

  assign empty    = (count == '0);
  assign push     = WR_EN && !FULL;
  assign head     = mem[rd_ptr];
  assign count_n  = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign half_end = (hcnt == H_LAST);
  assign byte_end = (state == SHIFT) && ph && half_end && (bcnt == 3'd7);

  always_ff @(posedge CLK)
    if (push) mem[wr_ptr] <= {WR_DC, WR_DATA};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      FULL   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      FULL  <= (count_n == FULL_CNT);
    end
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else     state <= state_n;

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE:  if (!empty) state_n = LOAD;
      LOAD:  begin
        pop     = 1'b1;
        state_n = SHIFT;
      end
      SHIFT: if (byte_end) state_n = empty ? GAP : LOAD;
      GAP:   if (gcnt == G_LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ph is the SCLK level of the current SHIFT cycle; SCLK itself shows it one cycle later
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CS   <= 1'b1;
      SCLK <= 1'b1;
      SDO  <= 1'b0;
      DC   <= 1'b0;
      BUSY <= 1'b0;
      hcnt <= '0;
      ph   <= 1'b0;
      bcnt <= '0;
      gcnt <= '0;
      sr   <= '0;
    end else begin
      BUSY <= (state != IDLE) || !empty;
      case (state)
        LOAD: begin
          sr   <= head[7:0];
          DC   <= head[8];
          SDO  <= head[7];
          CS   <= 1'b0;
          SCLK <= 1'b1;
          hcnt <= '0;
          ph   <= 1'b0;
          bcnt <= '0;
        end
        SHIFT: begin
          SCLK <= ph;
          gcnt <= '0;
          if (!ph && hcnt == '0) SDO <= sr[7];
          if (half_end) begin
            hcnt <= '0;
            ph   <= ~ph;
            if (ph) begin
              sr   <= {sr[6:0], 1'b0};
              bcnt <= bcnt + 3'd1;
            end
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        GAP: begin
          CS   <= 1'b1;
          SCLK <= 1'b1;
          gcnt <= gcnt + GW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef OLED_SPI_TXCNT_EN
  always_ff @(posedge CLK or posedge RST)
    if (RST)           TX_CNT <= '0;
    else if (byte_end) TX_CNT <= TX_CNT + 16'd1;
`endif

endmodule

// File: tb/tb_oled_spi_tx.sv
// Bench for oled_spi_tx: table of single-byte frames, hand sequences for multi-cycle corners, random bursts vs a panel-side model.
module tb_oled_spi_tx;
  localparam int CLK_DIV = 2;
  localparam int DEPTH   = 4;
  localparam int CS_GAP  = 2;
  localparam int GAP_END = 2 + 16*CLK_DIV + CS_GAP*CLK_DIV;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic WR_EN = 1'b0;
  logic [7:0] WR_DATA = '0;
  logic WR_DC = 1'b0;
  logic FULL, BUSY, CS, SDO, SCLK, DC;
`ifdef OLED_SPI_TXCNT_EN
  logic [15:0] TX_CNT;
`endif

  oled_spi_tx #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH), .CS_GAP(CS_GAP)) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .WR_DC(WR_DC),
    .FULL(FULL), .BUSY(BUSY), .CS(CS), .SDO(SDO), .SCLK(SCLK), .DC(DC)
`ifdef OLED_SPI_TXCNT_EN
    , .TX_CNT(TX_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q[$];
  bit allow_partial = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Panel model: shift SDO in on SCLK rising edges while CS is low
  logic [7:0] rx_sh = '0;
  int rx_nb = 0;
  logic rx_dc = 1'b0;
  logic m_ps = 1'b1;
  always @(negedge CLK) begin
    if (RST) begin
      rx_nb = 0;
    end else if (!CS) begin
      if (!m_ps && SCLK) begin
        if (rx_nb % 8 == 0) rx_dc = DC;
        else chk("dc_stable", DC, rx_dc);
        rx_sh = {rx_sh[6:0], SDO};
        rx_nb++;
        if (rx_nb % 8 == 0) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rx_unexpected: got %0h expected none", {rx_dc, rx_sh});
          end else begin
            chk("rx_byte", {rx_dc, rx_sh}, exp_q.pop_front());
          end
        end
      end
    end else begin
      if (rx_nb != 0 && !allow_partial) chk("frame_bits_mod8", rx_nb % 8, 0);
      rx_nb = 0;
    end
    m_ps = SCLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic [7:0] exp_bits;
    logic       exp_dc;
    int         exp_fall;
    int         exp_low;
    int         exp_edges;
    int         exp_gap;
  } vec_t;

  task automatic wait_idle(input int budget);
    int k;
    repeat (3) @(negedge CLK);
    for (k = 0; k < budget; k++) begin
      if (!BUSY) break;
      @(negedge CLK);
    end
    chk("busy_timeout", BUSY, 0);
  endtask

  task automatic run_single(input vec_t v);
    int fall = -1, low = 0, edges = 0, gap = 0;
    logic ps = 1'b1;
    bit done = 1'b0;
    @(negedge CLK);
    WR_EN = 1'b1; WR_DATA = v.data; WR_DC = v.dc;
    exp_q.push_back({v.exp_dc, v.exp_bits});
    for (int k = 1; k <= 200 && !done; k++) begin
      @(negedge CLK);
      if (k == 1) WR_EN = 1'b0;
      if (!CS) begin
        if (fall < 0) fall = k;
        low++;
        if (!ps && SCLK) edges++;
      end else if (fall >= 0) begin
        if (BUSY) gap++;
        else done = 1'b1;
      end
      ps = SCLK;
    end
    chk("single_done", done, 1);
    chk("single_cs_fall_cycle", fall, v.exp_fall);
    chk("single_cs_low_cycles", low, v.exp_low);
    chk("single_sclk_rises", edges, v.exp_edges);
    chk("single_cs_high_before_idle", gap, v.exp_gap);
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0, 3, 16*CLK_DIV+1, 8, CS_GAP*CLK_DIV};
    tbl[1] = '{8'h3C, 1'b1, 8'h3C, 1'b1, 3, 16*CLK_DIV+1, 8, CS_GAP*CLK_DIV};
    tbl[2] = '{8'h00, 1'b0, 8'h00, 1'b0, 3, 16*CLK_DIV+1, 8, CS_GAP*CLK_DIV};
    tbl[3] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 3, 16*CLK_DIV+1, 8, CS_GAP*CLK_DIV};
    tbl[4] = '{8'h81, 1'b0, 8'h81, 1'b0, 3, 16*CLK_DIV+1, 8, CS_GAP*CLK_DIV};

    repeat (2) @(negedge CLK);
    chk("rst_cs", CS, 1);
    chk("rst_sclk", SCLK, 1);
    chk("rst_sdo", SDO, 0);
    chk("rst_dc", DC, 0);
    chk("rst_full", FULL, 0);
    chk("rst_busy", BUSY, 0);
`ifdef OLED_SPI_TXCNT_EN
    chk("rst_txcnt", TX_CNT, 0);
`endif
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    foreach (tbl[i]) run_single(tbl[i]);

    // back-to-back bytes share one CS frame; DC flips while SCLK is high
    begin
      int rises = 0, edges = 0, low = 0, sw = 0;
      logic pcs = 1'b1, psc = 1'b1, pdc;
      bit fell = 1'b0, done = 1'b0;
      pdc = DC;
      @(negedge CLK);
      WR_EN = 1'b1; WR_DATA = 8'h81; WR_DC = 1'b0; exp_q.push_back({1'b0, 8'h81});
      @(negedge CLK);
      WR_DATA = 8'h7F; WR_DC = 1'b1; exp_q.push_back({1'b1, 8'h7F});
      for (int k = 2; k <= 300 && !done; k++) begin
        @(negedge CLK);
        if (k == 2) WR_EN = 1'b0;
        if (!CS) begin
          fell = 1'b1;
          low++;
          if (!psc && SCLK) edges++;
          if (!pcs && DC != pdc) begin
            sw++;
            chk("dc_switch_sclk_high", SCLK, 1);
          end
        end else begin
          if (!pcs) rises++;
          if (fell && !BUSY) done = 1'b1;
        end
        pcs = CS; psc = SCLK; pdc = DC;
      end
      chk("b2b_done", done, 1);
      chk("b2b_cs_rises", rises, 1);
      chk("b2b_sclk_rises", edges, 16);
      chk("b2b_cs_low_cycles", low, 2*(16*CLK_DIV+1));
      chk("b2b_dc_switches", sw, 1);
    end

    // fill the FIFO behind a byte in flight; the fifth queued write is dropped
    begin
      bit seen = 1'b0;
      @(negedge CLK);
      WR_EN = 1'b1; WR_DATA = 8'h00; WR_DC = 1'b0; exp_q.push_back({1'b0, 8'h00});
      @(negedge CLK);
      WR_EN = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge CLK);
        if (!SCLK) seen = 1'b1;
      end
      chk("fill_first_sclk_fall", seen, 1);
      for (int i = 1; i <= 5; i++) begin
        if (i == 4) chk("fill_full_before_4th", FULL, 0);
        if (i == 5) chk("fill_full_after_4th", FULL, 1);
        WR_EN = 1'b1; WR_DATA = 8'(i * 8'h11); WR_DC = 1'b1;
        if (i <= 4) exp_q.push_back({1'b1, 8'(i * 8'h11)});
        @(negedge CLK);
      end
      WR_EN = 1'b0;
      chk("fill_full_held", FULL, 1);
      wait_idle(600);
      chk("fill_all_received", exp_q.size(), 0);
    end

    // reset in the middle of bit 3 of 0xFF
    begin
      int e = 0, act = 0;
      bit hit = 1'b0;
      logic ps = 1'b1;
      @(negedge CLK);
      WR_EN = 1'b1; WR_DATA = 8'hFF; WR_DC = 1'b0;
      @(negedge CLK);
      WR_EN = 1'b0;
      for (int k = 0; k < 100 && !hit; k++) begin
        @(negedge CLK);
        if (!ps && SCLK) e++;
        if (e == 3 && !SCLK) hit = 1'b1;
        ps = SCLK;
      end
      chk("rst_mid_reached_bit3", hit, 1);
      allow_partial = 1'b1;
      RST = 1'b1;
      #1;
      chk("rst_mid_cs", CS, 1);
      chk("rst_mid_sclk", SCLK, 1);
      chk("rst_mid_sdo", SDO, 0);
      chk("rst_mid_busy", BUSY, 0);
      chk("rst_mid_full", FULL, 0);
      @(negedge CLK);
      RST = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge CLK);
        if (!SCLK || !CS) act++;
      end
      chk("rst_mid_quiet_100", act, 0);
      allow_partial = 1'b0;
      run_single('{8'h3C, 1'b0, 8'h3C, 1'b0, 3, 16*CLK_DIV+1, 8, CS_GAP*CLK_DIV});
    end

    // write landing on the last GAP cycle starts a fresh frame
    begin
      int falls = 0, hi = 0, hi_before = 0, edges = 0;
      logic pcs = 1'b1, psc = 1'b1;
      bit done = 1'b0;
      @(negedge CLK);
      WR_EN = 1'b1; WR_DATA = 8'h5A; WR_DC = 1'b1; exp_q.push_back({1'b1, 8'h5A});
      for (int k = 1; k <= 300 && !done; k++) begin
        @(negedge CLK);
        if (k == 1) WR_EN = 1'b0;
        if (k == GAP_END) begin
          WR_EN = 1'b1; WR_DATA = 8'hC3; WR_DC = 1'b0; exp_q.push_back({1'b0, 8'hC3});
        end
        if (k == GAP_END + 1) WR_EN = 1'b0;
        if (!CS) begin
          if (pcs) begin
            falls++;
            if (falls == 2) hi_before = hi;
          end
          hi = 0;
          if (!psc && SCLK) edges++;
        end else begin
          if (falls > 0) hi++;
          if (falls >= 2 && !BUSY) done = 1'b1;
        end
        pcs = CS; psc = SCLK;
      end
      chk("gapw_done", done, 1);
      chk("gapw_frames", falls, 2);
      chk("gapw_cs_high_ge4", int'(hi_before >= 4), 1);
      chk("gapw_sclk_rises", edges, 16);
    end

    // random bursts: back-to-back from idle keeps DEPTH+1 bytes, spaced bursts keep all
    for (int b = 0; b < 12; b++) begin
      int mode = $urandom_range(0, 1);
      int len  = mode ? $urandom_range(1, 4) : $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        logic [7:0] d  = 8'($urandom);
        logic       dc = 1'($urandom);
        @(negedge CLK);
        WR_EN = 1'b1; WR_DATA = d; WR_DC = dc;
        if (mode || i < DEPTH + 1) exp_q.push_back({dc, d});
        if (mode) begin
          @(negedge CLK);
          WR_EN = 1'b0;
          repeat ($urandom_range(0, 2)) @(negedge CLK);
        end
      end
      @(negedge CLK);
      WR_EN = 1'b0;
      wait_idle(1000);
      repeat ($urandom_range(0, 5)) @(negedge CLK);
    end
    chk("rand_all_received", exp_q.size(), 0);

`ifdef OLED_SPI_TXCNT_EN
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("txcnt_cleared", TX_CNT, 0);
    for (int i = 0; i < 3; i++) run_single(tbl[i]);
    chk("txcnt_three", TX_CNT, 3);
    @(negedge CLK);
    force dut.TX_CNT = 16'hFFFF;
    #1;
    release dut.TX_CNT;
    run_single(tbl[3]);
    chk("txcnt_wrap", TX_CNT, 0);
`endif

    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
